// File: rtl/mux_scan_pkg.sv
// Shared types and widths for the mux scan controller and its dwell counter.
package mux_scan_pkg;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned WORD_W = 1 << SEL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_dwell_counter.sv
// Dwell counter: counts settle cycles per select value, flags the last one.
module dwell_counter
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Decoded from the count register only, so no input reaches it combinationally.
  assign tc_c = (cnt == CNT_W'(DWELL - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux tree through every select, dwells on each, and captures Out into Word.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic              MuxOut,
  input  logic              Ready,
  output logic [SEL_W-1:0]  Sel,
  output logic [WORD_W-1:0] Word,
  output logic              Valid,
  output logic              Busy
);

  state_t state;
  logic   tc_c;
  logic   cnt_clr_c;
  logic   cnt_inc_c;

  // Counter sits at zero outside SCAN and restarts after every capture.
  assign cnt_clr_c = (state != SCAN) || tc_c;
  assign cnt_inc_c = (state == SCAN) && !tc_c;

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_c),
    .inc   (cnt_inc_c),
    .tc_c  (tc_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      Sel   <= '0;
      Word  <= '0;
      Valid <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state <= SCAN;
            Sel   <= '0;
            Word  <= '0;
            Busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (tc_c) begin
            Word[Sel] <= MuxOut;
            Sel       <= Sel + SEL_W'(1);
            // Last select captured: Sel wraps to 0 on its own.
            if (Sel == SEL_W'(WORD_W - 1)) begin
              state <= DONE;
              Valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (Ready) begin
            state <= IDLE;
            Valid <= 1'b0;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Valid <= 1'b0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 2: cycles each select value is held before MuxOut is sampled; legal range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Start, input, 1 bit: request to begin one scan; accepted only in IDLE.
REQ-005 SHALL have port MuxOut, input, 1 bit: Out of the downstream 4:1 mux tree built from 2:1 muxes, driven by Sel.
REQ-006 SHALL have port Sel, output, 2 bits: select to the mux tree; Sel[0] to first-level S, Sel[1] to second-level S.
REQ-007 SHALL have port Word, output, 4 bits: captured result; Word[i] = MuxOut sampled while Sel==i.
REQ-008 SHALL have port Valid, output, 1 bit: Word is complete and stable.
REQ-009 SHALL have port Ready, input, 1 bit: consumer accepts Word when Valid and Ready are both high at a rising edge.
REQ-010 SHALL have port Busy, output, 1 bit: high in SCAN and DONE.

Function
REQ-011 SHALL implement three states: IDLE, SCAN, DONE.
REQ-012 IDLE with Start=1 at an edge SHALL go to SCAN, set Sel=0 and dwell counter=0, and clear Word to 0; Start=0 SHALL stay in IDLE.
REQ-013 In SCAN, at each edge with counter<DWELL-1, the counter SHALL increment and Sel SHALL hold.
REQ-014 In SCAN, at each edge with counter==DWELL-1, the block SHALL write MuxOut to Word[Sel], reset the counter to 0, and set Sel to Sel+1 modulo 4.
REQ-015 The capture at Sel==3 SHALL wrap Sel to 0 and go to DONE.
REQ-016 Valid SHALL rise exactly 4*DWELL edges after the edge that accepts Start, e.g. 8 edges for DWELL=2.
REQ-017 Valid SHALL be high only in DONE; Word SHALL hold stable in DONE.
REQ-018 DONE with Ready=1 SHALL go to IDLE, with Valid low after that edge; Ready=0 SHALL hold DONE indefinitely.
REQ-019 Start SHALL be ignored in SCAN and DONE, including the cycle in which Valid&&Ready completes; a new scan needs Start in IDLE.
REQ-020 Ready SHALL be ignored outside DONE.
REQ-021 With DWELL=1, every SCAN edge SHALL be a capture edge.
REQ-022 All outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, Sel=0, counter=0, Word=0, Valid=0 and Busy=0, regardless of clk.
REQ-024 Reset asserted mid-SCAN or in DONE SHALL abort the scan and discard the partial Word; after release the block SHALL wait in IDLE for Start.
REQ-025 The first edge after rst_n deasserts SHALL be able to accept Start.

Structure
REQ-026 Package mux_scan_pkg SHALL hold the state enumeration (IDLE, SCAN, DONE), the counter width constant (8), and the Sel width constant (2).
REQ-027 The dwell counter SHALL be one sub-module, dwell_counter, with a clear input, an increment input, and a terminal-count output that is high when count==DWELL-1.
REQ-028 The verification bench SHALL instantiate mux_scan_ctrl with a mux tree of three 2:1 muxes driven by four constant bench inputs In0..In3.

Verification
REQ-029 Reset then idle: rst_n low for 3 cycles, Start=0 -> Sel=0, Word=0, Valid=0, Busy=0 throughout.
REQ-030 Basic scan: DWELL=2, In3..In0=1010b, Start pulse, Ready=1 -> Sel sequence 0,0,1,1,2,2,3,3; Valid high at edge +8; Word=1010b; IDLE the next cycle.
REQ-031 Backpressure: Ready=0 for 5 cycles after Valid -> Valid and Word=1010b held; Ready=1 -> Valid low after 1 edge.
REQ-032 DWELL=1 with In=0110b -> Valid at edge +4, Word=0110b; Start pulses during SCAN and DONE are ignored, with no second scan.
REQ-033 Reset mid-scan: DWELL=3, rst_n low at edge +5 -> all outputs reset immediately; a new Start after release gives a full correct Word.
REQ-034 Start in the same cycle as the Valid&&Ready handshake -> block returns to IDLE with Busy=0; only a later Start begins a new scan.
